ddma_arbiter: RTL and testbench

Round-robin arbiter sharing one DDMA engine among `NUM_REQ` requesters, e.g. several time-triggered configuration units or a CPU port. Each requester presents a target address and byte count; the arbiter latches one request, commands the DDMA engine and tracks it to completion. It then signals done to the winner and moves priority to the next requester. It sits between the requesters and the DDMA engine's command/status pins.

---
 rtl/ddma_arbiter_if.sv | 24 ++
 rtl/ddma_arbiter.sv | 121 ++++++++++++
 tb/tb_ddma_arbiter.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/ddma_arbiter_if.sv
// ddma_arbiter_if: requester and DDMA engine signal bundle around ddma_arbiter
interface ddma_arbiter_if #(
  parameter int MEMORY_BUS_WIDTH = 32,
  parameter int NUM_REQ          = 4
);
  logic [NUM_REQ-1:0]                  req_in;
  logic [NUM_REQ*MEMORY_BUS_WIDTH-1:0] addr_in;
  logic [NUM_REQ*MEMORY_BUS_WIDTH-1:0] nbytes_in;
  logic [NUM_REQ-1:0]                  grant_out;
  logic [NUM_REQ-1:0]                  done_out;
  logic                                error_out;
  logic [MEMORY_BUS_WIDTH-1:0]         ddma_addr_out;
  logic [MEMORY_BUS_WIDTH-1:0]         ddma_nbytes_out;
  logic                                ddma_cmd_out;
  logic                                ddma_status_in;
  modport master (
    output req_in, addr_in, nbytes_in, ddma_status_in,
    input  grant_out, done_out, error_out, ddma_addr_out, ddma_nbytes_out, ddma_cmd_out
  );
  modport slave (
    input  req_in, addr_in, nbytes_in, ddma_status_in,
    output grant_out, done_out, error_out, ddma_addr_out, ddma_nbytes_out, ddma_cmd_out
  );
endinterface

// File: rtl/ddma_arbiter.sv
// ddma_arbiter: round-robin sharing of one DDMA engine; watchdog built in with DDMA_ARB_WATCHDOG_EN
module ddma_arbiter #(
  parameter int MEMORY_BUS_WIDTH = 32,
  parameter int NUM_REQ          = 4,
  parameter int WDT_CYCLES       = 1024
) (
  input logic           clock,
  input logic           reset,
  ddma_arbiter_if.slave bus
);
  localparam int W  = MEMORY_BUS_WIDTH;
  localparam int LW = $clog2(NUM_REQ);
  typedef enum logic [1:0] {IDLE, ISSUE, BUSY, DONE} state_t;
  state_t             state, state_d;
  logic [LW-1:0]      last, last_d, win;
  logic [NUM_REQ-1:0] grant, grant_d, done, done_d;
  logic [W-1:0]       addr, addr_d, nbytes, nbytes_d;
  logic               cmd, cmd_d, skip, skip_d, found, wdt_hit;
  logic [W-1:0]       sel_nbytes;
  // first pending requester above the last winner, wrapping around
  always_comb begin
    found = 1'b0;
    win   = last;
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (!found && bus.req_in[(int'(last) + k) % NUM_REQ]) begin
        found = 1'b1;
        win   = LW'((int'(last) + k) % NUM_REQ);
      end
    end
  end
  assign sel_nbytes = bus.nbytes_in[int'(win)*W +: W];
  // next state and next registered outputs; a zero-byte grant spends an extra DONE cycle so done trails grant
  always_comb begin
    state_d  = state;
    last_d   = last;
    grant_d  = grant;
    done_d   = '0;
    cmd_d    = cmd;
    skip_d   = skip;
    addr_d   = addr;
    nbytes_d = nbytes;
    case (state)
      IDLE:
        if (found) begin
          grant_d  = NUM_REQ'(1) << win;
          last_d   = win;
          addr_d   = bus.addr_in[int'(win)*W +: W];
          nbytes_d = sel_nbytes;
          skip_d   = sel_nbytes == '0;
          cmd_d    = sel_nbytes != '0;
          state_d  = sel_nbytes == '0 ? DONE : ISSUE;
        end
      ISSUE:
        if (wdt_hit || bus.ddma_status_in) begin
          cmd_d   = 1'b0;
          done_d  = wdt_hit ? grant : '0;
          state_d = wdt_hit ? DONE : BUSY;
        end
      BUSY:
        if (wdt_hit || !bus.ddma_status_in) begin
          done_d  = grant;
          state_d = DONE;
        end
      default:
        if (skip) begin
          skip_d = 1'b0;
          done_d = grant;
        end else begin
          grant_d = '0;
          state_d = IDLE;
        end
    endcase
  end
  // state and output registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      last   <= LW'(NUM_REQ - 1);
      grant  <= '0;
      done   <= '0;
      cmd    <= 1'b0;
      skip   <= 1'b0;
      addr   <= '0;
      nbytes <= '0;
    end else begin
      state  <= state_d;
      last   <= last_d;
      grant  <= grant_d;
      done   <= done_d;
      cmd    <= cmd_d;
      skip   <= skip_d;
      addr   <= addr_d;
      nbytes <= nbytes_d;
    end
  end
`ifdef DDMA_ARB_WATCHDOG_EN
  localparam int CW = $clog2(WDT_CYCLES + 1);
  logic [CW-1:0] cnt;
  logic          error;
  assign wdt_hit = (state == ISSUE || state == BUSY) && cnt == CW'(WDT_CYCLES - 1);
  // cycles spent in the current ISSUE/BUSY state; error pulses alongside the forced done
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt   <= '0;
      error <= 1'b0;
    end else begin
      cnt   <= (state_d != state || !(state == ISSUE || state == BUSY)) ? '0 : cnt + 1'b1;
      error <= wdt_hit;
    end
  end
  assign bus.error_out = error;
`else
  assign wdt_hit       = 1'b0;
  assign bus.error_out = 1'b0;
`endif
  assign bus.grant_out       = grant;
  assign bus.done_out        = done;
  assign bus.ddma_cmd_out    = cmd;
  assign bus.ddma_addr_out   = addr;
  assign bus.ddma_nbytes_out = nbytes;
endmodule

// File: tb/tb_ddma_arbiter.sv
// tb_ddma_arbiter: randomized round-robin transfers checked against a priority/timing model
module tb_ddma_arbiter;
  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  req = '0;
  logic        status = 1'b0;
  logic [31:0] addr[4];
  logic [31:0] nb[4];
  int          n_vec = 0;
  int          n_bad = 0;
  int          last_m = 3;
  int          w;
  ddma_arbiter_if #(.MEMORY_BUS_WIDTH(32), .NUM_REQ(4)) bus();
  assign bus.req_in         = req;
  assign bus.addr_in        = {addr[3], addr[2], addr[1], addr[0]};
  assign bus.nbytes_in      = {nb[3], nb[2], nb[1], nb[0]};
  assign bus.ddma_status_in = status;
  ddma_arbiter #(.MEMORY_BUS_WIDTH(32), .NUM_REQ(4), .WDT_CYCLES(16)) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus)
  );
  always #5 clock = ~clock;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clock);
    #1;
  endtask
  function automatic int pick(input logic [3:0] r, input int l);
    for (int k = 1; k <= 4; k++)
      if (r[(l + k) % 4]) return (l + k) % 4;
    return 0;
  endfunction
  task automatic check_zero(input string tag);
    check({tag, "_grant"}, bus.grant_out, 0);
    check({tag, "_done"}, bus.done_out, 0);
    check({tag, "_cmd"}, bus.ddma_cmd_out, 0);
    check({tag, "_error"}, bus.error_out, 0);
    check({tag, "_addr"}, bus.ddma_addr_out, 0);
    check({tag, "_nbytes"}, bus.ddma_nbytes_out, 0);
  endtask
  task automatic txn(input int d1, input int d2, input bit withdraw, output int wo);
    int wm;
    wm = pick(req, last_m);
    last_m = wm;
    wo = wm;
    tick;
    check("grant", bus.grant_out, 4'b1 << wm);
    check("addr", bus.ddma_addr_out, addr[wm]);
    check("nbytes", bus.ddma_nbytes_out, nb[wm]);
    check("cmd_on", bus.ddma_cmd_out, nb[wm] != 0);
    check("done_early", bus.done_out, 0);
    if (withdraw) req[wm] = 1'b0;
    if (nb[wm] == 0) begin
      tick;
      check("zb_cmd", bus.ddma_cmd_out, 0);
    end else begin
      repeat (d1) begin
        tick;
        check("cmd_hold", bus.ddma_cmd_out, 1);
      end
      status = 1'b1;
      tick;
      check("cmd_drop", bus.ddma_cmd_out, 0);
      check("busy_done", bus.done_out, 0);
      repeat (d2 - 1) begin
        tick;
        check("busy_grant", bus.grant_out, 4'b1 << wm);
      end
      status = 1'b0;
      tick;
    end
    check("done", bus.done_out, 4'b1 << wm);
    check("done_grant", bus.grant_out, 4'b1 << wm);
    check("error", bus.error_out, 0);
    req[wm] = 1'b0;
    tick;
    check("exit_done", bus.done_out, 0);
    check("exit_grant", bus.grant_out, 0);
  endtask
  initial begin
    for (int i = 0; i < 4; i++) begin
      addr[i] = '0;
      nb[i]   = '0;
    end
    repeat (2) tick;
    check_zero("reset");
    reset = 1'b1;
    tick;
    check_zero("released");
    addr[0] = 32'h100;
    nb[0]   = 64;
    req     = 4'b0001;
    txn(2, 10, 1'b0, w);
    for (int i = 0; i < 4; i++) begin
      addr[i] = 32'h1000 * (i + 1);
      nb[i]   = 16 * (i + 1);
    end
    req = 4'b1111;
    for (int i = 0; i < 4; i++) txn(1, 3, 1'b0, w);
    req = 4'b0001;
    txn(0, 2, 1'b0, w);
    nb[2] = 0;
    req   = 4'b0100;
    txn(0, 1, 1'b0, w);
    nb[2] = 48;
    req   = 4'b1011;
    w = pick(req, last_m);
    tick;
    check("rst_grant", bus.grant_out, 4'b1 << w);
    status = 1'b1;
    tick;
    check("rst_busy_cmd", bus.ddma_cmd_out, 0);
    #3 reset = 1'b0;
    #1 check_zero("mid_reset");
    status = 1'b0;
    last_m = 3;
    repeat (2) tick;
    reset = 1'b1;
    txn(1, 2, 1'b0, w);
    repeat (40) begin
      for (int i = 0; i < 4; i++) begin
        if (!req[i] && $urandom_range(0, 2) == 0) begin
          addr[i] = $urandom;
          nb[i]   = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
          req[i]  = 1'b1;
        end
      end
      if (req == 0) begin
        nb[1]  = 32'd8;
        req[1] = 1'b1;
      end
      txn($urandom_range(0, 3), $urandom_range(1, 10), $urandom_range(0, 3) == 0, w);
    end
`ifdef DDMA_ARB_WATCHDOG_EN
    nb[0] = 8;
    req   = 4'b0001;
    tick;
    check("wdt_grant", bus.grant_out, 4'b0001);
    check("wdt_cmd", bus.ddma_cmd_out, 1);
    repeat (15) begin
      tick;
      check("wdt_wait_err", bus.error_out, 0);
      check("wdt_wait_cmd", bus.ddma_cmd_out, 1);
    end
    tick;
    check("wdt_error", bus.error_out, 1);
    check("wdt_done", bus.done_out, 4'b0001);
    check("wdt_cmd_off", bus.ddma_cmd_out, 0);
    req = 4'b0000;
    tick;
    check("wdt_error_end", bus.error_out, 0);
    check("wdt_done_end", bus.done_out, 0);
    check("wdt_grant_end", bus.grant_out, 0);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
